serial_tx_5bits: RTL and testbench



---
 rtl/serial_tx_5bits.sv | 130 +++++++++++++
 tb/tb_serial_tx_5bits.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_5bits.sv
// Parallel-in/serial-out transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. Each bit is held CLKS_PER_BIT clocks.
module serial_tx_5bits #(
    parameter int DATA_W       = 5,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] D_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BAUD_W-1:0] baud;
    logic              parity;
    logic              baud_end;

    assign shift_next = shift >> 1;
    assign baud_end   = (baud == BAUD_LAST);

    // tx_o/busy_o/done_o are registered here, so each is set to the value
    // the line must carry during the cycle that follows the edge.
    // NOTE: every register below uses <= so all updates see pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            parity  <= 1'b0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    tx_o    <= 1'b1;
                    busy_o  <= 1'b0;
                    baud    <= '0;
                    bit_cnt <= '0;
                    if (start_i) begin
                        shift  <= D_i;
                        parity <= ^D_i;
                        state  <= START;
                        tx_o   <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        tx_o    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_o  <= parity;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_o    <= shift_next[0];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud   <= '0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        tx_o   <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_o    <= 1'b1;
                    busy_o  <= 1'b0;
                    baud    <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_5bits.sv
// Scoreboard bench for serial_tx_5bits: one parity-enabled and one
// parity-disabled instance, each watched by its own frame monitor.
module tb_serial_tx_5bits;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] bits;   // slot i of the frame is bits[i]
        int         nbits;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       start0, start1;
    logic [4:0] d0, d1;
    logic [1:0] tx_s, busy_s, done_s;

    frame_t q0[$];
    frame_t q1[$];
    bit [1:0] cap;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int last_done = 0;
    int prev_done = 0;

    serial_tx_5bits #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .D_i(d0),
        .tx_o(tx_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0])
    );

    serial_tx_5bits #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .D_i(d1),
        .tx_o(tx_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (done_s[0] === 1'b1) done_cnt0 <= done_cnt0 + 1;
            if (done_s[1] === 1'b1) done_cnt1 <= done_cnt1 + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Pops one expected frame per busy rise and checks every cycle of it.
    task automatic monitor(input int d);
        frame_t     f;
        int         c = 0;
        bit         on = 0;
        bit         ok = 1;
        logic [2:0] obs, exp_v, bad_obs;
        forever begin
            @(negedge clk);
            if (rst) begin
                on = 0;
                cap[d] = 1'b0;
            end else begin
                if (!on && busy_s[d] === 1'b1) begin
                    check($sformatf("dut%0d_frame_pending", d), (qsize(d) > 0), 1);
                    if (qsize(d) > 0) begin
                        f = (d == 0) ? q0.pop_front() : q1.pop_front();
                        on = 1;
                        cap[d] = 1'b1;
                        c = 0;
                        ok = 1;
                    end
                end
                if (on) begin
                    obs = {busy_s[d], done_s[d], tx_s[d]};
                    if (c < f.nbits * CPB) begin
                        exp_v = {1'b1, 1'b0, f.bits[c / CPB]};
                        if (ok && obs !== exp_v) begin
                            ok = 0;
                            bad_obs = obs;
                        end
                        if (c % CPB == CPB - 1) begin
                            check($sformatf("dut%0d_slot%0d_busy_done_tx", d, c / CPB),
                                  ok ? obs : bad_obs, exp_v);
                            ok = 1;
                        end
                    end else begin
                        check($sformatf("dut%0d_frame_end_busy_done_tx", d), obs, 3'b011);
                        if (d == 0) begin
                            prev_done = last_done;
                            last_done = cyc;
                        end
                        on = 0;
                        cap[d] = 1'b0;
                    end
                    c++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send(input int d, input logic [4:0] data, input logic [7:0] bits, input int nb);
        frame_t f;
        f.bits  = bits;
        f.nbits = nb;
        @(negedge clk);
        if (d == 0) begin
            q0.push_back(f);
            d0 = data;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end else begin
            q1.push_back(f);
            d1 = data;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
    endtask

    task automatic wait_idle(input int d, input int budget);
        bit idle = 0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            #1;
            if (qsize(d) == 0 && !cap[d] && busy_s[d] !== 1'b1) idle = 1;
        end
        check($sformatf("dut%0d_idle_within_budget", d), idle, 1);
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        d0 = '0;
        d1 = '0;
        cap = '0;

        // Asynchronous reset between edges.
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_dut0", {tx_s[0], busy_s[0], done_s[0]}, 3'b100);
        check("rst_async_dut1", {tx_s[1], busy_s[1], done_s[1]}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_rst_dut0", {tx_s[0], busy_s[0], done_s[0]}, 3'b100);
        check("idle_after_rst_dut1", {tx_s[1], busy_s[1], done_s[1]}, 3'b100);

        // Basic frame and parity corners.
        send(0, 5'b10110, 8'b1110_1100, 8);
        wait_idle(0, 400);
        send(0, 5'b00000, 8'b1000_0000, 8);
        wait_idle(0, 400);
        send(0, 5'b11111, 8'b1111_1110, 8);
        wait_idle(0, 400);
        send(1, 5'b11111, 8'b0111_1110, 7);
        wait_idle(1, 400);

        // Start pulse and data change mid-frame are ignored.
        send(0, 5'b10110, 8'b1110_1100, 8);
        repeat (40) @(negedge clk);
        d0 = 5'b01010;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle(0, 400);
        repeat (200) @(negedge clk);
        check("no_frame_after_ignored_start", busy_s[0], 1'b0);

        // Back-to-back with start held high.
        q0.push_back('{bits: 8'b1100_0010, nbits: 8});
        q0.push_back('{bits: 8'b1011_1100, nbits: 8});
        @(negedge clk);
        d0 = 5'b00001;
        start0 = 1'b1;
        repeat (10) @(negedge clk);
        d0 = 5'b11110;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (busy_s[0] === 1'b0) seen = 1;
        end
        check("b2b_first_frame_ends", seen, 1);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (busy_s[0] === 1'b1) seen = 1;
        end
        check("b2b_second_frame_starts", seen, 1);
        start0 = 1'b0;
        wait_idle(0, 400);
        check("b2b_done_spacing", last_done - prev_done, 129);

        // Reset during data bit 2 (0 for this word), then a clean frame.
        send(0, 5'b11011, 8'b1011_0110, 8);
        repeat (50) @(negedge clk);
        check("pre_rst_tx_is_data_bit2", tx_s[0], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_frame_dut0", {tx_s[0], busy_s[0], done_s[0]}, 3'b100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_after_mid_rst", {tx_s[0], busy_s[0], done_s[0]}, 3'b100);
        send(0, 5'b00111, 8'b1100_1110, 8);
        wait_idle(0, 400);

        repeat (5) @(negedge clk);
        check("done_pulses_dut0", done_cnt0, 7);
        check("done_pulses_dut1", done_cnt1, 1);
        check("scoreboard_empty_dut0", q0.size(), 0);
        check("scoreboard_empty_dut1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
